// File: rtl/cfg_word_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cfg_seq_pkg
// Shared definitions for the configuration-word sequencer that feeds the
// sensor SPI register uploader: word field widths, register address map,
// the default word shown when nothing is queued, and a word-packing helper.
// -----------------------------------------------------------------------------
package cfg_seq_pkg;

  localparam int CFG_ADDR_W = 4;
  localparam int CFG_DATA_W = 12;
  localparam int CFG_WORD_W = CFG_ADDR_W + CFG_DATA_W;

  // Sensor register address map (upper nibble of a configuration word).
  localparam logic [CFG_ADDR_W-1:0] SEQUENCER   = 4'h0;
  localparam logic [CFG_ADDR_W-1:0] START1      = 4'h1;
  localparam logic [CFG_ADDR_W-1:0] START2      = 4'h2;
  localparam logic [CFG_ADDR_W-1:0] START3      = 4'h3;
  localparam logic [CFG_ADDR_W-1:0] RES1_LENGTH = 4'h4;
  localparam logic [CFG_ADDR_W-1:0] RES2_TIMER  = 4'h5;
  localparam logic [CFG_ADDR_W-1:0] RES3_TIMER  = 4'h6;
  localparam logic [CFG_ADDR_W-1:0] FT_TIMER    = 4'h7;

  // Packs an address and a data field into one upload word.
  function automatic logic [CFG_WORD_W-1:0] cfg_word(
    input logic [CFG_ADDR_W-1:0] addr,
    input logic [CFG_DATA_W-1:0] data
  );
    return {addr, data};
  endfunction

  // Sequencer register in slave mode: harmless when rewritten every gap.
  localparam logic [CFG_WORD_W-1:0] CFG_IDLE_WORD = {SEQUENCER, 12'h028};

endpackage

// File: rtl/cfg_word_sequencer_if.sv
// -----------------------------------------------------------------------------
// cfg_word_sequencer_if
// Host-side word write channel into the sequencer.
//   wr_valid : host presents a word this cycle (one word per cycle max)
//   wr_data  : {addr[3:0], data[11:0]}
//   wr_ready : sequencer can accept a word (FIFO not full)
// Handshake: a word transfers on every clock edge where wr_valid is high and
// wr_ready is high. A word offered while wr_ready is low is dropped (not
// stalled) and flagged by the sticky overflow output; the host is expected
// to watch wr_ready rather than hold wr_valid.
// -----------------------------------------------------------------------------
interface cfg_word_sequencer_if;
  import cfg_seq_pkg::*;

  logic                  wr_valid;
  logic [CFG_WORD_W-1:0] wr_data;
  logic                  wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/cfg_word_fifo.sv
// -----------------------------------------------------------------------------
// cfg_word_fifo
// Synchronous word FIFO, DEPTH entries (power of two).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_push/i_data : write request (ignored when full)
//   i_pop         : pop request (ignored when empty)
//   o_next_head   : head as it will be after this cycle's pop, read
//                   combinationally from the registered read pointer
//   o_count       : words held
//   o_full        : registered full flag
//   o_empty       : count is zero
// -----------------------------------------------------------------------------
module cfg_word_fifo
  import cfg_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [CFG_WORD_W-1:0]    i_data,
  input  logic                     i_pop,
  output logic [CFG_WORD_W-1:0]    o_next_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int unsigned DEPTH_U = DEPTH;
  localparam logic [AW:0] FULL_CNT = DEPTH_U[AW:0];

  logic [CFG_WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  r_full;

  logic        w_push;
  logic        w_pop;
  logic [AW:0] w_count_nxt;
  logic [AW-1:0] w_rd_sel;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) w_count_nxt = r_count + 1'b1;
    if (!w_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  assign w_rd_sel    = r_rd_ptr + AW'(w_pop);
  assign o_next_head = r_mem[w_rd_sel];
  assign o_count     = r_count;
  assign o_full      = r_full;
  assign o_empty     = (r_count == '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
    end
  end

endmodule

// File: rtl/cfg_word_sequencer.sv
// -----------------------------------------------------------------------------
// cfg_word_sequencer
// Buffers host configuration words and presents one per inter-frame gap to
// the SPI register uploader, together with the NDR frame index cNDR.
// All presentation changes happen one cycle after a frame-start event (rising
// edge of the synchronized fval), so advalue/cNDR are stable for the gap.
// Ports:
//   clock_20, reset   : 20 MHz clock, synchronous active-high reset
//   wr (slave)        : host word channel (wr_valid / wr_data / wr_ready)
//   ndr_en, ndr_len   : NDR cycle enable and length (0 treated as 1)
//   fval              : asynchronous sensor frame-valid
//   advalue, cNDR     : word and NDR index for the uploader
//   pending, overflow : words held, sticky dropped-write flag
// Build option: CFG_SEQ_NDR_EN builds the NDR counter; without it cNDR is 0,
// ndr_en/ndr_len are ignored and every frame start may pop and show a word.
// -----------------------------------------------------------------------------
module cfg_word_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int                    DEPTH     = 8,
  parameter logic [CFG_WORD_W-1:0] IDLE_WORD = CFG_IDLE_WORD
) (
  input  logic                     clock_20,
  input  logic                     reset,
  cfg_word_sequencer_if.slave      wr,
  input  logic                     ndr_en,
  input  logic [7:0]               ndr_len,
  input  logic                     fval,
  output logic [CFG_WORD_W-1:0]    advalue,
  output logic [7:0]               cNDR,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  // fval synchronizer, previous-value flop and registered frame-start pulse.
  logic r_fval_s1;
  logic r_fval_s2;
  logic r_fval_prev;
  logic r_evt;

  logic [CFG_WORD_W-1:0] r_advalue;
  logic                  r_shown_valid;
  logic                  r_overflow;

  logic [CFG_WORD_W-1:0] w_next_head;
  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_has_next;
  logic [7:0]            w_next_cndr;

  // The shown word was uploaded during the gap that just ended.
  assign w_push = wr.wr_valid;
  assign w_pop  = r_evt && r_shown_valid;

  // Count after this event's pop; a word pushed in the same cycle is not
  // counted, so it is first shown at the following event.
  assign w_has_next = w_pop ? (w_count > CW'(1)) : !w_empty;

  cfg_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clock_20),
    .rst         (reset),
    .i_push      (w_push),
    .i_data      (wr.wr_data),
    .i_pop       (w_pop),
    .o_next_head (w_next_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

`ifdef CFG_SEQ_NDR_EN
  logic [7:0] r_cndr;
  logic [7:0] w_ndr_max;

  assign w_ndr_max = (ndr_len == 8'd0) ? 8'd1 : ndr_len;

  // Wrap at max(ndr_len,1); a shrunk ndr_len or a dropped ndr_en restarts at 0.
  always_comb begin
    w_next_cndr = 8'd0;
    if (ndr_en && (r_cndr < w_ndr_max)) w_next_cndr = r_cndr + 8'd1;
  end

  always_ff @(posedge clock_20) begin
    if (reset)      r_cndr <= 8'd0;
    else if (r_evt) r_cndr <= w_next_cndr;
  end

  assign cNDR = r_cndr;
`else
  logic w_unused_ndr;
  assign w_unused_ndr = ^{ndr_en, ndr_len};
  assign w_next_cndr  = 8'd0;
  assign cNDR         = 8'd0;
`endif

  always_ff @(posedge clock_20) begin
    if (reset) begin
      // Synchronizer resets high so an fval already high creates no edge.
      r_fval_s1     <= 1'b1;
      r_fval_s2     <= 1'b1;
      r_fval_prev   <= 1'b1;
      r_evt         <= 1'b0;
      r_advalue     <= IDLE_WORD;
      r_shown_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_fval_s1   <= fval;
      r_fval_s2   <= r_fval_s1;
      r_fval_prev <= r_fval_s2;
      r_evt       <= r_fval_s2 && !r_fval_prev;

      if (wr.wr_valid && w_full) r_overflow <= 1'b1;

      if (r_evt) begin
        if ((w_next_cndr == 8'd0) && w_has_next) begin
          r_advalue     <= w_next_head;
          r_shown_valid <= 1'b1;
        end else begin
          r_advalue     <= IDLE_WORD;
          r_shown_valid <= 1'b0;
        end
      end
    end
  end

  assign wr.wr_ready = !w_full;
  assign advalue     = r_advalue;
  assign pending     = w_count;
  assign overflow    = r_overflow;

endmodule

// File: doc/cfg_word_sequencer.md
# cfg_word_sequencer

Upstream feeder for the sensor SPI register uploader. Buffers 16-bit register-write words ({addr[3:0], data[11:0]}) from the host-side command path and presents one word per inter-frame gap on `advalue`. Generates the `cNDR` non-destructive-readout frame index that the uploader uses to choose between a queued word and its built-in sequencer rewrite. All changes are made at frame start, so `advalue` and `cNDR` stay stable through the whole gap in which the uploader samples them.

## Interface
Parameters:
- DEPTH, 8: FIFO depth in words; power of two, 2..64.
- IDLE_WORD, 16'h0028: word shown when nothing is queued (sequencer register, slave mode).

Ports:
- clock_20  in  1  20 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  host word strobe, one word per cycle.
- wr_data  in  16  {addr[3:0], data[11:0]}.
- wr_ready  out  1  high when FIFO not full.
- ndr_en  in  1  enables the NDR frame cycle; sampled at frame start.
- ndr_len  in  8  NDR frames per cycle; value 0 is treated as 1.
- fval  in  1  sensor frame-valid; asynchronous, synchronized internally.
- advalue  out  16  word for the uploader.
- cNDR  out  8  NDR index; 0 means "upload advalue".
- pending  out  $clog2(DEPTH)+1  words currently held.
- overflow  out  1  sticky; set when a write is dropped.

## Operation
- **Reset values:**
  - advalue = IDLE_WORD, cNDR = 0, wr_ready = 1, pending = 0, overflow = 0.
  - shown_valid = 0.
  - fval synchronizer flops = 1, so an fval already high at reset release creates no edge.
- **Push:**
  - wr_valid && !full writes wr_data at the tail.
  - wr_valid && full drops the word and sets overflow. overflow clears only on reset.
- **Frame-start event E:** rising edge of the synchronized fval. At E, in order:
  1. If shown_valid = 1, pop the head. The word was uploaded in the gap that just ended.
  2. Compute next_cNDR:
     - ndr_en = 0: next_cNDR = 0.
     - ndr_en = 1: sequence 0, 1, …, max(ndr_len,1), then back to 0.
     - ndr_en falling mid-cycle forces the next value to 0.
  3. Load the presented word:
     - next_cNDR == 0 and the post-pop count > 0: advalue = new head, shown_valid = 1.
     - Otherwise: advalue = IDLE_WORD, shown_valid = 0.
- **Simultaneous push and pop at E:** pending is unchanged. The count used in step 3 excludes the word written in that same cycle; that word is first shown at the next E.
- **Between events:** advalue, cNDR and shown_valid hold their values.
- **NDR frames:** while cNDR != 0, queued words are neither shown nor popped.
- **Mid-operation reset:** clears the FIFO and all state at the next edge. Queued words are lost.

## Timing
- fval passes through a 2-flop synchronizer plus a prev-flop. E asserts for 1 cycle, 3 clock_20 edges after fval rises.
- advalue and cNDR update on the edge after E (latency 4 cycles from fval rise). They remain stable until the next E.
- Write-to-upload latency: the word appears at the next E and is uploaded in that frame's trailing gap.
- wr_ready = !full, registered. It reflects a pop in the cycle after E.
- pending updates on the same edge as the push or pop.
- fval pulses shorter than 2 cycles may be missed. Frames are always much longer, so no further handling is required.

## Configuration
- **CFG_SEQ_NDR_EN defined:** the NDR counter is built in and behaves as described above.
- **CFG_SEQ_NDR_EN undefined:**
  - The counter logic is removed; cNDR is tied to 8'd0.
  - ndr_en and ndr_len are ignored.
  - Every frame start may pop and show a word.

## Structure
- Shared package `cfg_seq_pkg`:
  - CFG_ADDR_W = 4, CFG_DATA_W = 12.
  - Register address constants (SEQUENCER = 4'h0, RES1_LENGTH = 4'h4, FT_TIMER = 4'h7, etc.).
  - Default IDLE_WORD.
- Sub-module `cfg_word_fifo`: synchronous FIFO with DEPTH parameter; push/pop, head, count, full and empty outputs. Reads of the next head are combinational from the registered read pointer.
- The top level holds the synchronizer, edge detect, NDR counter and presentation logic.

## Test plan
- **Reset with fval held high, then release:** no E occurs; advalue = 16'h0028, cNDR = 0.
- **Single word:** push 16'h71A5, then pulse fval.
  - advalue = 16'h71A5 four cycles after the rise.
  - At the next fval rise, pending goes 1 → 0 and advalue returns to 16'h0028.
- **Overflow:** push 9 words with DEPTH = 8.
  - wr_ready = 0 after the 8th; overflow = 1; pending = 8.
  - Then 8 frames present the words in push order.
- **NDR sequence:** CFG_SEQ_NDR_EN defined, ndr_en = 1, ndr_len = 2, 3 words queued.
  - cNDR over successive frames: 0, 1, 2, 0, 1, 2.
  - Words are shown only on cNDR = 0 frames; pending 3 → 2 → 1 at those pops.
- **Push coinciding with E while empty:** the word is not shown at that E and is shown at the following E.
- **Reset asserted mid-frame with 4 words queued:** on the next edge pending = 0, advalue = 16'h0028, overflow = 0.
